dot_tracker: RTL and testbench
==============================

Name: dot_tracker

Overview:
- Owns the `tilemap_dots` bitmap that the player-movement block reads.
- Takes the player's pixel position, clears the dot under the player, and accumulates score.
- Tracks the number of remaining dots and flags level clear.
- Sits between the player controller (position source) and the renderer/score display (bitmap and score sinks).

Parameters:
- TILE_SIZE, 20, tile edge in pixels.
- COLS, 32, tiles per row (640/20).
- ROWS, 24, tile rows (480/20).
- SCORE_W, 16, score register width.
- DOT_POINTS, 10, points added per dot eaten.
- INIT_MAP, {768{1'b0}}, initial dot bitmap; bit index = row*COLS + col.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  10  player pixel x (left edge of sprite).
- y  in  9  player pixel y (top edge of sprite).
- pos_valid  in  1  one-cycle strobe: x/y hold a new player position.
- restart  in  1  one-cycle strobe: reload INIT_MAP for a new level.
- tilemap_dots  out  COLS*ROWS  current dot bitmap, registered.
- score  out  SCORE_W  accumulated score.
- dots_left  out  10  dots remaining.
- ready  out  1  high in PLAY state.
- eat_pulse  out  1  one-cycle pulse when a dot is cleared.
- level_clear  out  1  high in CLEAR state.

Behaviour:
- Reset (async, active-high): tilemap_dots=INIT_MAP, score=0, dots_left=0, ready=0, eat_pulse=0, level_clear=0, state=COUNT, cnt_idx=0, pipeline valid bits=0.
- COUNT state:
  - Each clock examines tilemap_dots[cnt_idx]; if set, dots_left += 1; cnt_idx += 1.
  - On the edge that examines index COLS*ROWS-1: state->PLAY, ready=1 on that same edge.
  - ready therefore rises on the 768th clock edge after reset deasserts.
  - After counting, if dots_left==0, state->CLEAR instead of PLAY.
  - pos_valid is ignored in COUNT.
- PLAY state, 2-stage pipeline:
  - Stage 1 (edge after pos_valid): register col=x/TILE_SIZE, row=y/TILE_SIZE, and in_range=(x<COLS*TILE_SIZE && y<ROWS*TILE_SIZE).
  - Stage 2 (next edge): idx=row*COLS+col. If in_range and tilemap_dots[idx]==1:
    - clear bit idx;
    - dots_left -= 1;
    - score += DOT_POINTS, saturating at 2^SCORE_W-1;
    - eat_pulse=1 for exactly this cycle.
  - If stage 2 finds no dot, or the position is out of range: no state change, eat_pulse=0.
  - Total latency pos_valid -> bitmap/score update = 2 edges.
  - Back-to-back pos_valid strobes are accepted every cycle (fully pipelined).
  - The same tile presented twice consecutively scores once: stage 2 reads the bitmap after the prior clear. Forward the clear if stage 2 would otherwise see a stale bit.
- Transition to CLEAR: when the stage-2 clear brings dots_left from 1 to 0, state->CLEAR on that edge, ready=0, level_clear=1.
- CLEAR state: level_clear held high; pos_valid ignored; in-flight stage-1 data discarded.
- restart (any state):
  - On the next edge: tilemap_dots=INIT_MAP, dots_left=0, cnt_idx=0, state=COUNT, ready=0, level_clear=0, eat_pulse=0, pipeline flushed.
  - score is retained; only reset clears score.
- Simultaneous events:
  - restart with a stage-2 eat: restart wins; no score added, bitmap = INIT_MAP.
  - reset at any time, including mid-COUNT or mid-pipeline: immediate return to reset values.
- Arithmetic: col/row use integer division. idx is 10 bits (max 767). dots_left never underflows, because a clear only occurs for a set bit.

Test Plan:
- Reset release with INIT_MAP bits 33,34,35 set -> ready=0 for 767 edges, ready=1 after edge 768, dots_left=3, state PLAY.
- pos_valid with x=20, y=20 (idx 33) -> 2 edges later bit33=0, score=10, dots_left=2, eat_pulse high exactly 1 cycle; a repeat pos_valid at x=25, y=30 (same tile) -> score stays 10, no pulse.
- pos_valid at x=40 then x=60 on consecutive cycles (y=20) -> bits 34 and 35 cleared on consecutive edges, score=30, dots_left=0, level_clear=1, ready=0; a further pos_valid is ignored.
- pos_valid with x=650, y=20 -> no bitmap change, no eat_pulse, score unchanged.
- restart asserted in the same cycle as a stage-2 eat of bit 33 -> bitmap=INIT_MAP, score unchanged from its prior value, re-enter COUNT, dots_left=3 after 768 edges.
- SCORE_W=4, DOT_POINTS=10, two eats -> score saturates at 15; reset asserted mid-COUNT (cnt_idx≈400) -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/dot_tracker.sv
// -----------------------------------------------------------------------------
// dot_tracker
//
// Owns the dot bitmap of the maze. After reset or restart it counts the dots
// in the bitmap. It then clears the dot under the player whenever a new
// position arrives, adds points to the score and flags level clear once the
// last dot is eaten.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   x, y         player pixel position (top-left of sprite)
//   pos_valid    one-cycle strobe: x/y carry a new position
//   restart      one-cycle strobe: reload INIT_MAP and recount (score is kept)
//   tilemap_dots registered dot bitmap, bit index = row*COLS + col
//   score        accumulated score, saturating
//   dots_left    number of dots still in the bitmap
//   ready        high while accepting positions (PLAY)
//   eat_pulse    one-cycle pulse when a dot is cleared
//   level_clear  high once every dot is gone (CLEAR)
// -----------------------------------------------------------------------------
module dot_tracker #(
  parameter int TILE_SIZE  = 20,
  parameter int COLS       = 32,
  parameter int ROWS       = 24,
  parameter int SCORE_W    = 16,
  parameter int DOT_POINTS = 10,
  parameter logic [COLS*ROWS-1:0] INIT_MAP = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic                 pos_valid,
  input  logic                 restart,
  output logic [COLS*ROWS-1:0] tilemap_dots,
  output logic [SCORE_W-1:0]   score,
  output logic [9:0]           dots_left,
  output logic                 ready,
  output logic                 eat_pulse,
  output logic                 level_clear
);

  localparam int NUM_TILES = COLS * ROWS;
  localparam int IDX_W     = $clog2(NUM_TILES);
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int X_LIMIT   = COLS * TILE_SIZE;
  localparam int Y_LIMIT   = ROWS * TILE_SIZE;
  // Wide enough that score + DOT_POINTS can never wrap before the compare.
  localparam int SUM_W     = SCORE_W + 32;

  typedef enum logic [1:0] {
    ST_COUNT,
    ST_PLAY,
    ST_CLEAR
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0] cnt_idx;
  logic             cnt_last;
  logic [9:0]       count_total;

  // Stage-1 registers
  logic             s1_valid;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic             s1_in_range;

  logic [COL_W-1:0] col_calc;
  logic [ROW_W-1:0] row_calc;
  logic             in_range_calc;

  logic [IDX_W-1:0]   s2_idx;
  logic               eat;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  assign cnt_last    = (cnt_idx == IDX_W'(NUM_TILES - 1));
  assign count_total = dots_left + 10'(tilemap_dots[cnt_idx]);

  // col/row are truncated to their field width; out-of-range positions are
  // masked by in_range, so the truncated value never selects a tile.
  assign col_calc      = COL_W'(32'(x) / TILE_SIZE);
  assign row_calc      = ROW_W'(32'(y) / TILE_SIZE);
  assign in_range_calc = (32'(x) < X_LIMIT) && (32'(y) < Y_LIMIT);

  assign s2_idx = IDX_W'(s1_row) * IDX_W'(COLS) + IDX_W'(s1_col);

  // Stage 2 reads the registered bitmap. A clear made by the previous stage-2
  // is already in the register on this cycle, so a repeated tile can never see
  // a stale bit and no separate forwarding path is needed.
  assign eat = (state == ST_PLAY) && s1_valid && s1_in_range &&
               tilemap_dots[s2_idx];

  assign score_sum  = SUM_W'(score) + SUM_W'(DOT_POINTS);
  assign score_next = (score_sum > SUM_W'({SCORE_W{1'b1}})) ?
                      {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_COUNT;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of always_comb is what prevents a
  // latch when a branch leaves state_next unassigned.
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ST_COUNT;
    end else begin
      unique case (state)
        ST_COUNT: if (cnt_last) state_next = (count_total == 10'd0) ? ST_CLEAR : ST_PLAY;
        ST_PLAY:  if (eat && (dots_left == 10'd1)) state_next = ST_CLEAR;
        ST_CLEAR: state_next = ST_CLEAR;
        default:  state_next = ST_COUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready       = (state == ST_PLAY);
    level_clear = (state == ST_CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the bitmap is a plain flop vector, not a RAM, so it is reset to
  // INIT_MAP like any other register and restart can reload it in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tilemap_dots <= INIT_MAP;
      score        <= '0;
      dots_left    <= '0;
      cnt_idx      <= '0;
      eat_pulse    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_col       <= '0;
      s1_row       <= '0;
      s1_in_range  <= 1'b0;
    end else if (restart) begin
      // Restart wins over a coincident stage-2 eat; score is deliberately kept.
      tilemap_dots <= INIT_MAP;
      dots_left    <= '0;
      cnt_idx      <= '0;
      eat_pulse    <= 1'b0;
      s1_valid     <= 1'b0;
    end else begin
      eat_pulse   <= 1'b0;
      // Positions are only accepted in PLAY; anything captured on the edge
      // that enters CLEAR is dropped because stage 2 is gated by PLAY.
      s1_valid    <= pos_valid && (state == ST_PLAY);
      s1_col      <= col_calc;
      s1_row      <= row_calc;
      s1_in_range <= in_range_calc;

      if (state == ST_COUNT) begin
        dots_left <= count_total;
        cnt_idx   <= cnt_last ? '0 : cnt_idx + IDX_W'(1);
      end

      if (eat) begin
        tilemap_dots[s2_idx] <= 1'b0;
        dots_left            <= dots_left - 10'd1;
        score                <= score_next;
        eat_pulse            <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dot_tracker.sv
// -----------------------------------------------------------------------------
// tb_dot_tracker
//
// Directed bench for dot_tracker. Two instances share one stimulus stream: the
// default 16-bit score instance and a 4-bit score instance that must saturate
// at 15. INIT_MAP has dots at indices 33, 34 and 35 (row 1, cols 1..3).
// -----------------------------------------------------------------------------
module tb_dot_tracker;

  localparam int N = 768;
  localparam logic [N-1:0] INIT = (768'b1 << 33) | (768'b1 << 34) | (768'b1 << 35);

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   x;
  logic [8:0]   y;
  logic         pos_valid;
  logic         restart;

  logic [N-1:0] tilemap_dots;
  logic [15:0]  score;
  logic [9:0]   dots_left;
  logic         ready;
  logic         eat_pulse;
  logic         level_clear;

  logic [N-1:0] s_tilemap_dots;
  logic [3:0]   s_score;
  logic [9:0]   s_dots_left;
  logic         s_ready;
  logic         s_eat_pulse;
  logic         s_level_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_map;
  logic         early_ready;

  always #5 clk = ~clk;

  dot_tracker #(.INIT_MAP(INIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .pos_valid    (pos_valid),
    .restart      (restart),
    .tilemap_dots (tilemap_dots),
    .score        (score),
    .dots_left    (dots_left),
    .ready        (ready),
    .eat_pulse    (eat_pulse),
    .level_clear  (level_clear)
  );

  dot_tracker #(.SCORE_W(4), .DOT_POINTS(10), .INIT_MAP(INIT)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .pos_valid    (pos_valid),
    .restart      (restart),
    .tilemap_dots (s_tilemap_dots),
    .score        (s_score),
    .dots_left    (s_dots_left),
    .ready        (s_ready),
    .eat_pulse    (s_eat_pulse),
    .level_clear  (s_level_clear)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges, remembering whether ready rose early.
  task automatic run_edges(input int n);
    early_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ready) early_ready = 1'b1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    x         = '0;
    y         = '0;
    pos_valid = 1'b0;
    restart   = 1'b0;
    exp_map   = INIT;

    // ---------------- reset values ----------------
    #3;
    check("rst_map",         tilemap_dots, INIT);
    check("rst_score",       score, 0);
    check("rst_dots_left",   dots_left, 0);
    check("rst_ready",       ready, 0);
    check("rst_eat_pulse",   eat_pulse, 0);
    check("rst_level_clear", level_clear, 0);

    tick();
    reset = 1'b0;

    // ---------------- initial count ----------------
    run_edges(767);
    check("cnt_ready_early", early_ready, 0);
    tick();
    check("cnt_ready_768",   ready, 1);
    check("cnt_dots_left",   dots_left, 3);
    check("cnt_level_clear", level_clear, 0);

    // ---------------- eat idx 33 ----------------
    x = 10'd20; y = 9'd20; pos_valid = 1'b1;
    tick();                                     // stage 1
    pos_valid = 1'b0;
    check("eat33_s1_pulse",  eat_pulse, 0);
    check("eat33_s1_map",    tilemap_dots, exp_map);
    tick();                                     // stage 2
    exp_map[33] = 1'b0;
    check("eat33_map",       tilemap_dots, exp_map);
    check("eat33_score",     score, 10);
    check("eat33_sat_score", s_score, 10);
    check("eat33_dots_left", dots_left, 2);
    check("eat33_pulse",     eat_pulse, 1);
    tick();
    check("eat33_pulse_end", eat_pulse, 0);

    // Same tile again at a different pixel inside it: no score.
    x = 10'd25; y = 9'd30; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    tick();
    check("rep33_score",     score, 10);
    check("rep33_pulse",     eat_pulse, 0);
    check("rep33_dots_left", dots_left, 2);

    // ---------------- out of range ----------------
    x = 10'd650; y = 9'd20; pos_valid = 1'b1;
    tick();
    x = 10'd680;                                // truncated col would hit idx 34
    tick();
    pos_valid = 1'b0;
    check("oor650_pulse",    eat_pulse, 0);
    tick();
    check("oor680_pulse",    eat_pulse, 0);
    check("oor_map",         tilemap_dots, exp_map);
    check("oor_score",       score, 10);
    check("oor_dots_left",   dots_left, 2);

    // ---------------- back-to-back eats 34, 35 ----------------
    x = 10'd40; y = 9'd20; pos_valid = 1'b1;
    tick();
    x = 10'd60;
    tick();                                     // stage 2 of 34
    pos_valid = 1'b0;
    exp_map[34] = 1'b0;
    check("eat34_map",       tilemap_dots, exp_map);
    check("eat34_score",     score, 20);
    check("eat34_sat_score", s_score, 15);
    check("eat34_dots_left", dots_left, 1);
    check("eat34_pulse",     eat_pulse, 1);
    tick();                                     // stage 2 of 35
    exp_map[35] = 1'b0;
    check("eat35_map",       tilemap_dots, exp_map);
    check("eat35_score",     score, 30);
    check("eat35_sat_score", s_score, 15);
    check("eat35_dots_left", dots_left, 0);
    check("eat35_pulse",     eat_pulse, 1);
    check("eat35_clear",     level_clear, 1);
    check("eat35_ready",     ready, 0);

    // pos_valid in CLEAR is ignored
    x = 10'd20; y = 9'd20; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    check("clr_pulse_a",     eat_pulse, 0);
    tick();
    check("clr_pulse_b",     eat_pulse, 0);
    check("clr_score",       score, 30);
    check("clr_level_clear", level_clear, 1);

    // ---------------- restart and recount ----------------
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs1_map",         tilemap_dots, INIT);
    check("rs1_score",       score, 30);
    check("rs1_dots_left",   dots_left, 0);
    check("rs1_level_clear", level_clear, 0);
    check("rs1_ready",       ready, 0);
    run_edges(768);
    check("rs1_ready_768",   ready, 1);
    check("rs1_dots_left3",  dots_left, 3);

    // ---------------- restart coincident with stage-2 eat ----------------
    x = 10'd20; y = 9'd20; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    restart   = 1'b1;
    tick();
    restart   = 1'b0;
    check("rs2_map",         tilemap_dots, INIT);
    check("rs2_score",       score, 30);
    check("rs2_sat_score",   s_score, 15);
    check("rs2_pulse",       eat_pulse, 0);
    check("rs2_ready",       ready, 0);
    check("rs2_dots_left",   dots_left, 0);
    run_edges(767);
    check("rs2_ready_early", early_ready, 0);
    tick();
    check("rs2_ready_768",   ready, 1);
    check("rs2_dots_left3",  dots_left, 3);

    // ---------------- reset mid-COUNT ----------------
    restart = 1'b1;
    tick();
    restart = 1'b0;
    run_edges(400);
    check("mid_dots_left",   dots_left, 3);
    check("mid_ready",       ready, 0);
    reset = 1'b1;
    #1;
    check("arst_map",        tilemap_dots, INIT);
    check("arst_score",      score, 0);
    check("arst_sat_score",  s_score, 0);
    check("arst_dots_left",  dots_left, 0);
    check("arst_ready",      ready, 0);
    check("arst_pulse",      eat_pulse, 0);
    check("arst_clear",      level_clear, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
